// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Size codes, FSM states, grant ids and the default memory latency.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RMW_WAIT,
    ST_WRITE,
    ST_RESP
  } state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_e;

  localparam int MEM_LATENCY_DEF = 1;

  // Data access that must be rejected before touching memory.
  function automatic logic d_misaligned(
    input size_e      sz,
    input logic [1:0] lo
  );
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals.
// slave = arbiter view, master = requesters plus memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
) ();

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic              m_op;
  logic [31:0]       m_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_size, d_addr, d_wdata,
    input  m_rdata,
    output i_ack, i_rdata, i_err,
    output d_ack, d_rdata, d_err,
    output m_addr, m_wdata, m_op
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_size, d_addr, d_wdata,
    output m_rdata,
    input  i_ack, i_rdata, i_err,
    input  d_ack, d_rdata, d_err,
    input  m_addr, m_wdata, m_op
  );

endinterface

// File: rtl/mem_arbiter_store_merge.sv
// Merges a right-aligned byte/half store into the old memory word.
// Word size replaces the whole word; illegal size leaves it untouched.
module mem_arbiter_store_merge
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o
);

  // Overwrite only the addressed lane(s).
  always_comb begin
    merged_o = old_i;
    case (size_i)
      SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      SZ_WORD: merged_o = wdata_i;
      default: merged_o = old_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch vs load/store arbiter for one single-port memory.
// Alternating grant, fixed-latency reads, read-modify-write sub-word stores.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int ADDR_W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic         busy
);

  localparam int CNT_W =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  gnt_e              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  size_e             size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              err_q, err_d;

  gnt_e              pick;
  logic              bad;
  size_e             d_size_in;
  logic [31:0]       merged;
  logic              resp;

  assign d_size_in = size_e'(bus.d_size);

  mem_arbiter_store_merge u_merge (
    .old_i    (bus.m_rdata),
    .wdata_i  (wdata_q),
    .size_i   (size_q),
    .lane_i   (addr_q[1:0]),
    .merged_o (merged)
  );

  // State, grant, counter and captured data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= GNT_DATA;
      last_q    <= GNT_DATA;
      cnt_q     <= '0;
      addr_q    <= '0;
      size_q    <= SZ_WORD;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  // Arbitration and access sequencing.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d     = err_q;
    pick      = GNT_DATA;
    bad       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          if (bus.i_req && bus.d_req)
            pick = (last_q == GNT_DATA) ? GNT_INST : GNT_DATA;
          else
            pick = bus.i_req ? GNT_INST : GNT_DATA;
          gnt_d = pick;
          cnt_d = '0;
          if (pick == GNT_INST) begin
            addr_d  = bus.i_addr;
            bad     = |bus.i_addr[1:0];
            state_d = bad ? ST_RESP : ST_RD_WAIT;
          end else begin
            addr_d = bus.d_addr;
            size_d = d_size_in;
            bad    = d_misaligned(d_size_in, bus.d_addr[1:0]);
            if (bad) begin
              state_d = ST_RESP;
            end else if (!bus.d_we) begin
              state_d = ST_RD_WAIT;
            end else if (d_size_in == SZ_WORD) begin
              wdata_d = bus.d_wdata;
              state_d = ST_WRITE;
            end else begin
              wdata_d = bus.d_wdata;
              state_d = ST_RMW_WAIT;
            end
          end
          err_d = bad;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (gnt_q == GNT_INST)
            i_rdata_d = bus.m_rdata;
          else
            d_rdata_d = bus.m_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RMW_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          wdata_d = merged;
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        last_d  = gnt_q;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign resp = (state_q == ST_RESP);
  assign busy = (state_q != ST_IDLE);

  assign bus.i_ack   = resp && (gnt_q == GNT_INST);
  assign bus.d_ack   = resp && (gnt_q == GNT_DATA);
  assign bus.i_err   = bus.i_ack && err_q;
  assign bus.d_err   = bus.d_ack && err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

  // Address is presented in the grant cycle so the read starts at once.
  assign bus.m_addr  = rst ? '0 : {addr_d[ADDR_W-1:2], 2'b00};
  assign bus.m_wdata = wdata_q;
  assign bus.m_op    = (state_q == ST_WRITE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at memory latency 1 and 3.
// Two DUT instances, each with its own behavioural memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy1, busy3;
  bit   pre = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.ADDR_W(32)) bus1 ();
  mem_arbiter_if #(.ADDR_W(32)) bus3 ();

  mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus1),
    .busy (busy1)
  );

  mem_arbiter #(.MEM_LATENCY(3), .ADDR_W(32)) u_dut3 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus3),
    .busy (busy3)
  );

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] p1, p2;
  int          wr1 = 0;
  int          wr3 = 0;
  logic [31:0] wa1 = '0;
  logic [31:0] wd1 = '0;
  bit          both = 1'b0;

  always #5 clk = ~clk;

  // Memories: 1-cycle read for bus1, 3-stage read pipe for bus3.
  always @(posedge clk) begin
    if (pre) begin
      mem1[10'h040] <= 32'h00500093;
      mem1[10'h041] <= 32'h0A0B0C0D;
      mem1[10'h080] <= 32'h11223344;
      mem1[10'h082] <= 32'h01020304;
      mem3[10'h0C0] <= 32'hCAFEF00D;
    end else begin
      if (bus1.m_op) mem1[bus1.m_addr[11:2]] <= bus1.m_wdata;
      if (bus3.m_op) mem3[bus3.m_addr[11:2]] <= bus3.m_wdata;
    end
    bus1.m_rdata <= mem1[bus1.m_addr[11:2]];
    p1 <= mem3[bus3.m_addr[11:2]];
    p2 <= p1;
    bus3.m_rdata <= p2;
  end

  // Write-pulse monitor.
  always @(posedge clk) begin
    if (bus1.m_op) begin
      wr1 = wr1 + 1;
      wa1 = bus1.m_addr;
      wd1 = bus1.m_wdata;
    end
    if (bus3.m_op) wr3 = wr3 + 1;
  end

  // Both acks in one cycle is never legal.
  always @(negedge clk) begin
    if ((bus1.i_ack && bus1.d_ack) || (bus3.i_ack && bus3.d_ack))
      both = 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_i(input bit u3, input logic [31:0] a);
    if (u3) begin
      bus3.i_req = 1'b1; bus3.i_addr = a;
    end else begin
      bus1.i_req = 1'b1; bus1.i_addr = a;
    end
  endtask

  task automatic start_d(input bit u3, input logic we,
                         input logic [1:0] sz,
                         input logic [31:0] a,
                         input logic [31:0] wd);
    if (u3) begin
      bus3.d_req = 1'b1; bus3.d_we = we; bus3.d_size = sz;
      bus3.d_addr = a; bus3.d_wdata = wd;
    end else begin
      bus1.d_req = 1'b1; bus1.d_we = we; bus1.d_size = sz;
      bus1.d_addr = a; bus1.d_wdata = wd;
    end
  endtask

  // Count cycles to ack (inclusive), then drop req on the ending edge.
  task automatic wait_ack(input bit u3, input bit dp,
                          output int lat,
                          output logic [31:0] rd,
                          output logic er);
    lat = 0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (!u3 && !dp && bus1.i_ack) begin
        lat = k; rd = bus1.i_rdata; er = bus1.i_err;
      end
      if (!u3 && dp && bus1.d_ack) begin
        lat = k; rd = bus1.d_rdata; er = bus1.d_err;
      end
      if (u3 && !dp && bus3.i_ack) begin
        lat = k; rd = bus3.i_rdata; er = bus3.i_err;
      end
      if (u3 && dp && bus3.d_ack) begin
        lat = k; rd = bus3.d_rdata; er = bus3.d_err;
      end
    end
    @(posedge clk); #1;
    if (u3) begin
      if (dp) bus3.d_req = 1'b0; else bus3.i_req = 1'b0;
    end else begin
      if (dp) bus1.d_req = 1'b0; else bus1.i_req = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          w0;
    int          n;
    logic        ord [4];
    logic [31:0] rdv [4];

    rst = 1'b1;
    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0;
    bus1.d_we = 0; bus1.d_size = 2'b10;
    bus1.d_addr = '0; bus1.d_wdata = '0;
    bus3.i_req = 0; bus3.i_addr = '0; bus3.d_req = 0;
    bus3.d_we = 0; bus3.d_size = 2'b10;
    bus3.d_addr = '0; bus3.d_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      ord[i] = 1'b0; rdv[i] = '0;
    end

    @(negedge clk);
    pre = 1'b0;
    chk("rst_acks", {30'd0, bus1.i_ack, bus1.d_ack}, 32'd0);
    chk("rst_errs", {30'd0, bus1.i_err, bus1.d_err}, 32'd0);
    chk("rst_mop", {31'd0, bus1.m_op}, 32'd0);
    chk("rst_busy", {30'd0, busy1, busy3}, 32'd0);
    chk("rst_maddr", bus1.m_addr, 32'd0);
    chk("rst_mwdata", bus1.m_wdata, 32'd0);
    chk("rst_irdata", bus1.i_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    start_i(0, 32'h100);
    wait_ack(0, 0, lat, rd, er);
    chk("fetch_lat", 32'(lat), 32'd3);
    chk("fetch_data", rd, 32'h00500093);
    chk("fetch_err", {31'd0, er}, 32'd0);

    start_i(0, 32'h102);
    wait_ack(0, 0, lat, rd, er);
    chk("fetch_mis_lat", 32'(lat), 32'd2);
    chk("fetch_mis_err", {31'd0, er}, 32'd1);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus1.i_req = 1; bus1.i_addr = 32'h100;
    bus1.d_req = 1; bus1.d_we = 0;
    bus1.d_size = 2'b10; bus1.d_addr = 32'h104;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus1.i_ack) begin
        ord[n] = 1'b1; rdv[n] = bus1.i_rdata; n++;
      end else if (bus1.d_ack) begin
        ord[n] = 1'b0; rdv[n] = bus1.d_rdata; n++;
      end
    end
    @(posedge clk); #1;
    bus1.i_req = 0; bus1.d_req = 0;
    chk("alt_count", 32'(n), 32'd4);
    chk("alt_order", {28'd0, ord[0], ord[1], ord[2], ord[3]},
        32'hA);
    chk("alt_idata", rdv[0], 32'h00500093);
    chk("alt_ddata", rdv[1], 32'h0A0B0C0D);

    w0 = wr1;
    start_d(0, 1, 2'b00, 32'h202, 32'h000000AB);
    wait_ack(0, 1, lat, rd, er);
    chk("sb_lat", 32'(lat), 32'd4);
    chk("sb_err", {31'd0, er}, 32'd0);
    chk("sb_writes", 32'(wr1 - w0), 32'd1);
    chk("sb_waddr", wa1, 32'h200);
    chk("sb_wdata", wd1, 32'h11AB3344);

    start_d(0, 1, 2'b01, 32'h202, 32'h0000BEEF);
    wait_ack(0, 1, lat, rd, er);
    chk("sh_wdata", wd1, 32'hBEEF3344);
    start_d(0, 1, 2'b00, 32'h200, 32'h00000055);
    wait_ack(0, 1, lat, rd, er);
    chk("sb0_wdata", wd1, 32'hBEEF3355);

    w0 = wr1;
    start_d(0, 1, 2'b01, 32'h201, 32'h00001234);
    wait_ack(0, 1, lat, rd, er);
    chk("sh_mis_lat", 32'(lat), 32'd2);
    chk("sh_mis_err", {31'd0, er}, 32'd1);
    start_d(0, 0, 2'b11, 32'h200, 32'h0);
    wait_ack(0, 1, lat, rd, er);
    chk("bad_size_err", {31'd0, er}, 32'd1);
    chk("err_no_write", 32'(wr1 - w0), 32'd0);

    w0 = wr1;
    start_d(0, 1, 2'b10, 32'h204, 32'hDEADBEEF);
    wait_ack(0, 1, lat, rd, er);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_writes", 32'(wr1 - w0), 32'd1);
    chk("sw_waddr", wa1, 32'h204);
    chk("sw_wdata", wd1, 32'hDEADBEEF);

    start_d(0, 0, 2'b10, 32'h200, 32'h0);
    wait_ack(0, 1, lat, rd, er);
    chk("lw_merged", rd, 32'hBEEF3355);

    start_d(1, 0, 2'b10, 32'h300, 32'h0);
    wait_ack(1, 1, lat, rd, er);
    chk("l3_lat", 32'(lat), 32'd5);
    chk("l3_data", rd, 32'hCAFEF00D);
    start_d(1, 1, 2'b01, 32'h302, 32'h00001234);
    wait_ack(1, 1, lat, rd, er);
    chk("sh3_lat", 32'(lat), 32'd6);
    chk("sh3_writes", 32'(wr3), 32'd1);
    start_d(1, 0, 2'b10, 32'h300, 32'h0);
    wait_ack(1, 1, lat, rd, er);
    chk("l3_merged", rd, 32'h1234F00D);

    w0 = wr1;
    start_d(0, 1, 2'b00, 32'h208, 32'h00000077);
    @(posedge clk); #1;
    chk("rmw_busy", {31'd0, busy1}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_busy", {31'd0, busy1}, 32'd0);
    chk("rr_mop", {31'd0, bus1.m_op}, 32'd0);
    chk("rr_dack", {31'd0, bus1.d_ack}, 32'd0);
    chk("rr_maddr", bus1.m_addr, 32'd0);
    chk("rr_mwdata", bus1.m_wdata, 32'd0);
    chk("rr_drdata", bus1.d_rdata, 32'd0);
    bus1.d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rr_no_write", 32'(wr1 - w0), 32'd0);
    chk("rr_mem", mem1[10'h082], 32'h01020304);
    start_i(0, 32'h100);
    wait_ack(0, 0, lat, rd, er);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_data", rd, 32'h00500093);

    chk("no_dual_ack", {31'd0, both}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
